// File: rtl/poly_synth_pkg.sv
// Shared types, note table and scancode decode for the polyphonic keyboard front end.
package poly_synth_pkg;

   typedef enum logic [1:0] {
      V_IDLE    = 2'd0,
      V_ATTACK  = 2'd1,
      V_SUSTAIN = 2'd2,
      V_RELEASE = 2'd3
   } voice_state_e;

   typedef struct packed {
      logic       pressed;
      logic [7:0] code;
      logic [4:0] sem;
   } key_evt_t;

   localparam logic [4:0] SEM_LAST   = 5'd12;
   localparam logic [4:0] SEM_OCT_DN = 5'd13;
   localparam logic [4:0] SEM_OCT_UP = 5'd14;
   localparam logic [4:0] SEM_NONE   = 5'd31;

   // Hz x 256, octave 4 (C4 .. C5)
   localparam logic [31:0] NOTE_FREQ [0:12] = '{
      32'd66980,  32'd70963,  32'd75183,  32'd79653,  32'd84390,
      32'd89408,  32'd94724,  32'd100357, 32'd106324, 32'd112647,
      32'd119345, 32'd126442, 32'd133961
   };

   function automatic logic [4:0] scancode_to_semitone(input logic [7:0] code);
      logic [4:0] sem;
      case (code)
         8'h1A:   sem = 5'd0;
         8'h1B:   sem = 5'd1;
         8'h22:   sem = 5'd2;
         8'h23:   sem = 5'd3;
         8'h21:   sem = 5'd4;
         8'h2A:   sem = 5'd5;
         8'h34:   sem = 5'd6;
         8'h32:   sem = 5'd7;
         8'h33:   sem = 5'd8;
         8'h31:   sem = 5'd9;
         8'h3B:   sem = 5'd10;
         8'h3A:   sem = 5'd11;
         8'h41:   sem = 5'd12;
         8'h4E:   sem = SEM_OCT_DN;
         8'h55:   sem = SEM_OCT_UP;
         default: sem = SEM_NONE;
      endcase
      return sem;
   endfunction

   function automatic logic [31:0] note_freq(input logic [4:0] sem);
      return (sem <= SEM_LAST) ? NOTE_FREQ[sem[3:0]] : 32'd0;
   endfunction

endpackage

// File: rtl/voice_envelope.sv
// Per-voice attack/sustain/release level generator; commands override the tick step.
//
// state     | meaning
// ----------+---------------------------------------------------
// V_IDLE    | silent, volume 0, frequency retained
// V_ATTACK  | ramp up by ATTACK_STEP per tick until all-ones
// V_SUSTAIN | hold full level while the key is down
// V_RELEASE | ramp down by RELEASE_STEP per tick until 0
module voice_envelope
   import poly_synth_pkg::*;
#(
   parameter int               VOL_W        = 32,
   parameter logic [VOL_W-1:0] ATTACK_STEP  = 32'h0100_0000,
   parameter logic [VOL_W-1:0] RELEASE_STEP = 32'h0040_0000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             cmd_attack,
   input  logic             cmd_release,
   input  logic             cmd_steal,
   output logic [VOL_W-1:0] vol,
   output voice_state_e     state
);

   localparam logic [VOL_W-1:0] VOL_MAX = '1;

   voice_state_e     state_q, state_d;
   logic [VOL_W-1:0] vol_q, vol_d;

   always_comb begin
      state_d = state_q;
      vol_d   = vol_q;
      if (cmd_steal) begin
         state_d = V_ATTACK;
         vol_d   = '0;
      end else if (cmd_attack) begin
         state_d = V_ATTACK;
      end else if (cmd_release) begin
         state_d = V_RELEASE;
      end else if (tick) begin
         case (state_q)
            V_ATTACK: begin
               if (vol_q > VOL_MAX - ATTACK_STEP) begin
                  vol_d   = VOL_MAX;
                  state_d = V_SUSTAIN;
               end else begin
                  vol_d = vol_q + ATTACK_STEP;
               end
            end
            V_RELEASE: begin
               if (vol_q <= RELEASE_STEP) begin
                  vol_d   = '0;
                  state_d = V_IDLE;
               end else begin
                  vol_d = vol_q - RELEASE_STEP;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= V_IDLE;
         vol_q   <= '0;
      end else begin
         state_q <= state_d;
         vol_q   <= vol_d;
      end
   end

   assign vol   = vol_q;
   assign state = state_q;

endmodule

// File: rtl/poly_voice_allocator.sv
// ps2_key to per-voice frequency/volume with LRA stealing and envelopes.
// Optional octave keys ('-' / '=') when OCTAVE_SHIFT_EN is defined.
module poly_voice_allocator
   import poly_synth_pkg::*;
#(
   parameter int               NUM_VOICES   = 8,
   parameter int               FREQ_W       = 32,
   parameter int               VOL_W        = 32,
   parameter int               TICK_DIV     = 24000,
   parameter logic [VOL_W-1:0] ATTACK_STEP  = 32'h0100_0000,
   parameter logic [VOL_W-1:0] RELEASE_STEP = 32'h0040_0000
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [10:0]                  ps2_key,
   output logic [NUM_VOICES*FREQ_W-1:0] frequencies,
   output logic [NUM_VOICES*VOL_W-1:0]  voice_volumes,
   output logic [$clog2(NUM_VOICES):0]  voices_active,
   output logic [7:0]                   drop_count
);

   localparam int            AW        = $clog2(NUM_VOICES);
   localparam int            TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DIV - 1);

   logic              init_q, init_d, tog_q, tog_d, tick;
   logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
   key_evt_t          ev, hold_q, hold_d, s1_q, s1_d, s2_q, s2_d;
   logic              ev_mapped, ev_new, pipe_free;
   logic              hold_v_q, hold_v_d, s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   logic [FREQ_W-1:0] s2_freq_q, s2_freq_d, freq_new;
   logic [7:0]        drop_q, drop_d;
   logic [AW:0]       active_q, active_d;
   logic [AW-1:0]     age_q  [NUM_VOICES];
   logic [AW-1:0]     age_d  [NUM_VOICES];
   logic [7:0]        key_q  [NUM_VOICES];
   logic [7:0]        key_d  [NUM_VOICES];
   logic [FREQ_W-1:0] freq_q [NUM_VOICES];
   logic [FREQ_W-1:0] freq_d [NUM_VOICES];
   voice_state_e      st     [NUM_VOICES];
   logic [VOL_W-1:0]  vol    [NUM_VOICES];
   logic [NUM_VOICES-1:0] held, cmd_attack, cmd_release, cmd_steal;
   logic              hit, idle_any, steal;
   logic [AW-1:0]     hit_idx, idle_idx, old_idx, tgt;
`ifdef OCTAVE_SHIFT_EN
   logic [2:0]        oct_q, oct_d;
`endif

   assign init_d     = 1'b1;
   assign tog_d      = ps2_key[10];
   assign tick       = (tick_cnt_q == '0);
   assign tick_cnt_d = tick ? TICK_LOAD : tick_cnt_q - 1'b1;

   // The first cycle after reset only primes tog_q, so a stale toggle level never fires.
   always_comb begin
      ev.pressed = ps2_key[9];
      ev.code    = ps2_key[7:0];
      ev.sem     = scancode_to_semitone(ps2_key[7:0]);
`ifdef OCTAVE_SHIFT_EN
      ev_mapped  = (ev.sem <= SEM_OCT_UP);
`else
      ev_mapped  = (ev.sem <= SEM_LAST);
`endif
      ev_new     = init_q && (ps2_key[10] != tog_q) && !ps2_key[8] && ev_mapped;
   end

   always_comb begin
      hold_v_d  = hold_v_q;
      hold_d    = hold_q;
      s1_v_d    = 1'b0;
      s1_d      = s1_q;
      s2_v_d    = s1_v_q;
      s2_d      = s1_q;
      s2_freq_d = FREQ_W'(note_freq(s1_q.sem));
      drop_d    = drop_q;
      pipe_free = !s1_v_q && !s2_v_q;
      if (pipe_free && hold_v_q) begin
         s1_v_d   = 1'b1;
         s1_d     = hold_q;
         hold_v_d = ev_new;
         if (ev_new) hold_d = ev;
      end else if (pipe_free && ev_new) begin
         s1_v_d = 1'b1;
         s1_d   = ev;
      end else if (ev_new) begin
         if (!hold_v_q) begin
            hold_v_d = 1'b1;
            hold_d   = ev;
         end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end
   end

`ifdef OCTAVE_SHIFT_EN
   assign freq_new = (s2_freq_q << oct_q) >> 4;
`else
   assign freq_new = s2_freq_q;
`endif

   always_comb begin
      cmd_attack  = '0;
      cmd_release = '0;
      cmd_steal   = '0;
      held        = '0;
      hit         = 1'b0;
      idle_any    = 1'b0;
      hit_idx     = '0;
      idle_idx    = '0;
      old_idx     = '0;
      age_d       = age_q;
      key_d       = key_q;
      freq_d      = freq_q;
`ifdef OCTAVE_SHIFT_EN
      oct_d       = oct_q;
`endif
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         held[i] = (key_q[i] == s2_q.code) && (st[i] == V_ATTACK || st[i] == V_SUSTAIN);
         if (held[i]) begin
            hit     = 1'b1;
            hit_idx = AW'(i);
         end
         if (st[i] == V_IDLE) begin
            idle_any = 1'b1;
            idle_idx = AW'(i);
         end
         if (age_q[i] == AW'(NUM_VOICES - 1)) old_idx = AW'(i);
      end
      steal = !hit && !idle_any;
      tgt   = hit ? hit_idx : (idle_any ? idle_idx : old_idx);
      if (s2_v_q && s2_q.sem <= SEM_LAST) begin
         if (s2_q.pressed) begin
            cmd_steal[tgt]  = steal;
            cmd_attack[tgt] = !steal;
            key_d[tgt]      = s2_q.code;
            freq_d[tgt]     = freq_new;
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (AW'(i) == tgt)           age_d[i] = '0;
               else if (age_q[i] < age_q[tgt]) age_d[i] = age_q[i] + AW'(1);
            end
         end else begin
            cmd_release = held;
         end
      end
`ifdef OCTAVE_SHIFT_EN
      else if (s2_v_q && s2_q.pressed) begin
         if (s2_q.sem == SEM_OCT_DN && oct_q != 3'd0) oct_d = oct_q - 3'd1;
         if (s2_q.sem == SEM_OCT_UP && oct_q != 3'd7) oct_d = oct_q + 3'd1;
      end
`endif
   end

   always_comb begin
      active_d = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         if (st[i] != V_IDLE) active_d = active_d + (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         init_q     <= 1'b0;
         tog_q      <= 1'b0;
         tick_cnt_q <= TICK_LOAD;
         hold_v_q   <= 1'b0;
         hold_q     <= '0;
         s1_v_q     <= 1'b0;
         s1_q       <= '0;
         s2_v_q     <= 1'b0;
         s2_q       <= '0;
         s2_freq_q  <= '0;
         drop_q     <= '0;
         active_q   <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            age_q[i]  <= AW'(i);
            key_q[i]  <= '0;
            freq_q[i] <= '0;
         end
`ifdef OCTAVE_SHIFT_EN
         oct_q      <= 3'd4;
`endif
      end else begin
         init_q     <= init_d;
         tog_q      <= tog_d;
         tick_cnt_q <= tick_cnt_d;
         hold_v_q   <= hold_v_d;
         hold_q     <= hold_d;
         s1_v_q     <= s1_v_d;
         s1_q       <= s1_d;
         s2_v_q     <= s2_v_d;
         s2_q       <= s2_d;
         s2_freq_q  <= s2_freq_d;
         drop_q     <= drop_d;
         active_q   <= active_d;
         age_q      <= age_d;
         key_q      <= key_d;
         freq_q     <= freq_d;
`ifdef OCTAVE_SHIFT_EN
         oct_q      <= oct_d;
`endif
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      voice_envelope #(
         .VOL_W        (VOL_W),
         .ATTACK_STEP  (ATTACK_STEP),
         .RELEASE_STEP (RELEASE_STEP)
      ) u_env (
         .clk         (clk),
         .reset_n     (reset_n),
         .tick        (tick),
         .cmd_attack  (cmd_attack[g]),
         .cmd_release (cmd_release[g]),
         .cmd_steal   (cmd_steal[g]),
         .vol         (vol[g]),
         .state       (st[g])
      );
      assign frequencies[g*FREQ_W +: FREQ_W] = freq_q[g];
      assign voice_volumes[g*VOL_W +: VOL_W] = vol[g];
   end

   assign voices_active = active_q;
   assign drop_count    = drop_q;

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Scoreboard bench for poly_voice_allocator: allocation, stealing, envelopes, drops, reset.
module tb_poly_voice_allocator;

   localparam int NV = 8;
   localparam int FW = 32;
   localparam int VW = 32;
   localparam int TD = 4;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [10:0]     ps2_key = '0;
   logic [NV*FW-1:0] frequencies;
   logic [NV*VW-1:0] voice_volumes;
   logic [3:0]      voices_active;
   logic [7:0]      drop_count;

   int   n_chk = 0;
   int   n_fail = 0;
   logic tog = 1'b0;
   int   steps;

   typedef struct {
      string       tag;
      int          voice;
      logic [31:0] freq;
   } exp_t;
   exp_t exp_q[$];

   localparam logic [31:0] NF [0:12] = '{
      32'd66980,  32'd70963,  32'd75183,  32'd79653,  32'd84390,
      32'd89408,  32'd94724,  32'd100357, 32'd106324, 32'd112647,
      32'd119345, 32'd126442, 32'd133961
   };
   localparam logic [7:0] KEY_CODE [0:12] = '{
      8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34,
      8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A, 8'h41
   };

   poly_voice_allocator #(
      .NUM_VOICES (NV),
      .FREQ_W     (FW),
      .VOL_W      (VW),
      .TICK_DIV   (TD)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ps2_key       (ps2_key),
      .frequencies   (frequencies),
      .voice_volumes (voice_volumes),
      .voices_active (voices_active),
      .drop_count    (drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] freq_of(input int v);
      return frequencies[v*FW +: FW];
   endfunction

   function automatic logic [31:0] vol_of(input int v);
      return voice_volumes[v*VW +: VW];
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic key(input logic pressed, input logic [7:0] code, input logic ext = 1'b0);
      tog     = ~tog;
      ps2_key = {tog, pressed, ext, code};
   endtask

   task automatic expect_alloc(input string tag, input int v, input logic [31:0] f);
      exp_t e;
      e.tag   = tag;
      e.voice = v;
      e.freq  = f;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(e.tag, freq_of(e.voice), e.freq);
      end
   endtask

   // Counts level changes (one per envelope tick) until the target is reached, bounded.
   task automatic ramp(input int v, input logic [31:0] target, output int n);
      logic [31:0] prev;
      int c;
      n    = 0;
      c    = 0;
      prev = vol_of(v);
      while (vol_of(v) !== target && c < 6000) begin
         @(negedge clk);
         c++;
         if (vol_of(v) !== prev) n++;
         prev = vol_of(v);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      cyc(2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      cyc(3);
      reset_n = 1'b1;
      cyc(2);
      chk("rst_freq", frequencies, 0);
      chk("rst_vol", voice_volumes, 0);
      chk("rst_active", voices_active, 0);
      chk("rst_drop", drop_count, 0);

      // single note: attack to full scale
      key(1'b1, KEY_CODE[0]);
      expect_alloc("t1_freq_v0", 0, NF[0]);
      cyc(3);
      drain();
      chk("t1_vol_start", vol_of(0), 0);
      ramp(0, 32'hFFFF_FFFF, steps);
      chk("t1_attack_ticks", steps, 256);
      chk("t1_active", voices_active, 1);

      // release down to idle
      key(1'b0, KEY_CODE[0]);
      ramp(0, 32'h0, steps);
      chk("t3_release_ticks", steps, 1024);
      cyc(1);
      chk("t3_active", voices_active, 0);
      chk("t3_freq_kept", freq_of(0), NF[0]);

      // fill all voices, then steal the oldest
      for (int i = 0; i < NV; i++) begin
         key(1'b1, KEY_CODE[i]);
         expect_alloc($sformatf("t2_freq_v%0d", i), i, NF[i]);
         cyc(3);
         drain();
         cyc(1);
      end
      key(1'b1, KEY_CODE[11]);
      expect_alloc("t2_steal_freq", 0, NF[11]);
      cyc(3);
      drain();
      chk("t2_steal_vol", vol_of(0), 0);
      cyc(1);
      chk("t2_active", voices_active, 8);
      chk("t2_drop", drop_count, 0);

      key(1'b1, KEY_CODE[1]);
      expect_alloc("t2_retrig_freq", 1, NF[1]);
      cyc(3);
      drain();
      chk("t2_retrig_vol_kept", vol_of(1) != 0, 1);
      chk("t2_v0_untouched", freq_of(0), NF[11]);

      // reset while an event sits in the pipeline
      key(1'b1, KEY_CODE[4]);
      cyc(2);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_freq", |frequencies, 0);
      chk("t5_rst_vol", |voice_volumes, 0);
      chk("t5_rst_active", voices_active, 0);
      @(negedge clk);
      cyc(1);
      reset_n = 1'b1;
      cyc(6);
      chk("t5_no_alloc", |frequencies, 0);
      chk("t5_active_after", voices_active, 0);

      // three back-to-back toggles: third is dropped
      key(1'b1, KEY_CODE[0]);
      cyc(1);
      key(1'b1, KEY_CODE[1]);
      cyc(1);
      key(1'b1, KEY_CODE[2]);
      expect_alloc("t4_first_v0", 0, NF[0]);
      expect_alloc("t4_second_v1", 1, NF[1]);
      expect_alloc("t4_third_dropped", 2, 0);
      cyc(10);
      drain();
      chk("t4_drop", drop_count, 1);
      chk("t4_active", voices_active, 2);

      // extended and unmapped codes are ignored without counting drops
      key(1'b1, KEY_CODE[3], 1'b1);
      cyc(1);
      key(1'b1, 8'h1C);
      cyc(8);
      chk("t4_ignored_drop", drop_count, 1);
      chk("t4_ignored_active", voices_active, 2);
      chk("t4_ignored_v2", freq_of(2), 0);

      // octave keys
      do_reset();
      key(1'b1, 8'h55);
      cyc(5);
      key(1'b1, 8'h55);
      cyc(5);
      key(1'b1, KEY_CODE[0]);
`ifdef OCTAVE_SHIFT_EN
      expect_alloc("t6_oct_freq", 0, 32'd267920);
`else
      expect_alloc("t6_oct_freq", 0, NF[0]);
`endif
      cyc(3);
      drain();
      cyc(1);
      chk("t6_drop", drop_count, 0);
      chk("t6_active", voices_active, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
